// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word and the memory arbiter state encoding.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_A = 2'd1,
    MEM_B = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [3:0] full_mask = 4'hF;

endpackage

// File: rtl/mem_arbiter_register.sv
// Loadable holding register with synchronous active-high clear.
module register #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port (A) and a data port (B) onto one memory bus,
// serving A before B and completing both with a single joint resp pulse.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int width = $bits(rv32i_word)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_a,
  input  logic [width-1:0] address_a,
  output logic [width-1:0] rdata_a,
  output logic             resp_a,
  input  logic             read_b,
  input  logic             write_b,
  input  logic [width-1:0] address_b,
  input  logic [width-1:0] wdata_b,
  input  logic [3:0]       wmask_b,
  output logic [width-1:0] rdata_b,
  output logic             resp_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic [width-1:0] mem_address,
  output logic [width-1:0] mem_wdata,
  output logic [3:0]       mem_byte_enable,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_resp
);

  arb_state_t       state, state_next;
  logic             req_a, req_b, op_write;
  logic [width-1:0] addr_a, addr_b, wdata;
  logic [3:0]       wmask;
  logic             load_a, load_b;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Requests are captured only while idle; DONE drops them so a held request
  // is re-sampled by the following IDLE cycle rather than re-served directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_a    <= 1'b0;
      req_b    <= 1'b0;
      op_write <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      wdata    <= '0;
      wmask    <= 4'h0;
    end else if (state == IDLE) begin
      req_a    <= read_a;
      req_b    <= read_b | write_b;
      op_write <= write_b;
      addr_a   <= address_a;
      addr_b   <= address_b;
      wdata    <= wdata_b;
      wmask    <= wmask_b;
    end else if (state == DONE) begin
      req_a    <= 1'b0;
      req_b    <= 1'b0;
    end
  end

  always_comb begin
    state_next      = state;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = 4'h0;
    load_a          = 1'b0;
    load_b          = 1'b0;
    resp_a          = ~req_a;
    resp_b          = ~req_b;

    unique case (state)
      IDLE: begin
        resp_a = ~read_a;
        resp_b = ~(read_b | write_b);
        if (read_a)
          state_next = MEM_A;
        else if (read_b | write_b)
          state_next = MEM_B;
      end
      MEM_A: begin
        mem_read        = 1'b1;
        mem_address     = addr_a;
        mem_byte_enable = full_mask;
        if (mem_resp) begin
          load_a     = 1'b1;
          state_next = req_b ? MEM_B : DONE;
        end
      end
      MEM_B: begin
        mem_write       = op_write;
        mem_read        = ~op_write;
        mem_address     = addr_b;
        mem_wdata       = wdata;
        mem_byte_enable = op_write ? wmask : full_mask;
        if (mem_resp) begin
          load_b     = ~op_write;
          state_next = DONE;
        end
      end
      DONE: begin
        resp_a     = 1'b1;
        resp_b     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  register #(.width(width)) u_rdata_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_a),
    .d     (mem_rdata),
    .q     (rdata_a)
  );

  register #(.width(width)) u_rdata_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_b),
    .d     (mem_rdata),
    .q     (rdata_b)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected memory
// beats and completions; monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;

  typedef struct {
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          beat_edge;
  } acc_t;

  typedef struct {
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    int          done_edge;
  } cpl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_a = 1'b0;
  logic [31:0] address_a = '0;
  logic [31:0] rdata_a;
  logic        resp_a;
  logic        read_b = 1'b0;
  logic        write_b = 1'b0;
  logic [31:0] address_b = '0;
  logic [31:0] wdata_b = '0;
  logic [3:0]  wmask_b = 4'h0;
  logic [31:0] rdata_b;
  logic        resp_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata = 32'h5A5A_5A5A;
  logic        mem_resp = 1'b0;

  acc_t        acc_q[$];
  cpl_t        cpl_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_count = 0;
  logic        reset_at_edge = 1'b1;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        prev_both = 1'b1;
  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;
  int          base;

  mem_arbiter #(.width(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_a          (read_a),
    .address_a       (address_a),
    .rdata_a         (rdata_a),
    .resp_a          (resp_a),
    .read_b          (read_b),
    .write_b         (write_b),
    .address_b       (address_b),
    .wdata_b         (wdata_b),
    .wmask_b         (wmask_b),
    .rdata_b         (rdata_b),
    .resp_b          (resp_b),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_count++;
    reset_at_edge = reset;
  end

  // Memory model: answers after mem_wait stall cycles; under reset it fires a
  // bogus response that the DUT must ignore.
  always begin
    @(negedge clk);
    #1;
    mem_resp  = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    if (mem_read || mem_write) begin
      if (reset) begin
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        wait_cnt  = 0;
      end else if (wait_cnt == mem_wait) begin
        mem_resp  = 1'b1;
        mem_rdata = (mem_read && rd_q.size() != 0) ? rd_q.pop_front() : 32'h0BAD_0BAD;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always begin : monitor
    acc_t ea;
    cpl_t ec;
    @(negedge clk);
    #2;
    if (!reset && !reset_at_edge) begin
      if (mem_read || mem_write) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_access rd=%b wr=%b addr=%h at edge %0d", mem_read, mem_write, mem_address, edge_count);
        end else begin
          ea = acc_q[0];
          if (mem_write !== ea.write || mem_read !== !ea.write || mem_address !== ea.address ||
              mem_byte_enable !== ea.be || (ea.write && mem_wdata !== ea.wdata)) begin
            errors++;
            $display("[TB] FAIL access got rd=%b wr=%b addr=%h be=%h wdata=%h, want wr=%b addr=%h be=%h wdata=%h",
                     mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, ea.write, ea.address, ea.be, ea.wdata);
          end
          if (mem_resp) begin
            void'(acc_q.pop_front());
            checks++;
            if (edge_count != ea.beat_edge) begin
              errors++;
              $display("[TB] FAIL beat_cycle got edge %0d, want edge %0d", edge_count, ea.beat_edge);
            end
          end
        end
      end
      if (resp_a && resp_b && !prev_both) begin
        checks++;
        if (cpl_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_resp at edge %0d", edge_count);
        end else begin
          ec = cpl_q.pop_front();
          if (rdata_a !== ec.rdata_a || rdata_b !== ec.rdata_b || edge_count != ec.done_edge) begin
            errors++;
            $display("[TB] FAIL completion got a=%h b=%h edge %0d, want a=%h b=%h edge %0d",
                     rdata_a, rdata_b, edge_count, ec.rdata_a, ec.rdata_b, ec.done_edge);
          end
        end
      end
    end
    prev_both = resp_a && resp_b;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [31:0] aa, input logic rb, input logic wb,
                               input logic [31:0] ab, input logic [31:0] wd, input logic [3:0] wm);
    @(negedge clk);
    read_a = ra; address_a = aa;
    read_b = rb; write_b = wb; address_b = ab; wdata_b = wd; wmask_b = wm;
    base = edge_count;
  endtask

  // Drop requests and scramble operands; the DUT must keep its latched copies.
  task automatic releaseInputs();
    @(negedge clk);
    read_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    address_a = 32'hFFFF_FFF0; address_b = 32'hFFFF_FF00;
    wdata_b = 32'h1111_1111; wmask_b = 4'b1001;
  endtask

  task automatic pushAcc(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be, input int beat);
    acc_t e;
    e.write = wr; e.address = addr; e.wdata = wd; e.be = be; e.beat_edge = beat;
    acc_q.push_back(e);
  endtask

  task automatic pushCpl(input int done);
    cpl_t e;
    e.rdata_a = model_a; e.rdata_b = model_b; e.done_edge = done;
    cpl_q.push_back(e);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((acc_q.size() != 0 || cpl_q.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (acc_q.size() != 0 || cpl_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s pending acc=%0d cpl=%0d, want 0 and 0", name, acc_q.size(), cpl_q.size());
      acc_q.delete();
      cpl_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("reset_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("reset_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("reset_rdata_a", rdata_a, 32'd0);
    checkOutput("reset_rdata_b", rdata_b, 32'd0);
    checkOutput("reset_resp_a", {31'd0, resp_a}, 32'd1);
    checkOutput("reset_resp_b", {31'd0, resp_b}, 32'd1);

    // Fetch only, zero-wait
    mem_wait = 0;
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rd_q.push_back(32'h0000_0013);
    pushAcc(1'b0, 32'h60, 32'h0, 4'hF, base + 1);
    model_a = 32'h0000_0013;
    pushCpl(base + 2);
    releaseInputs();
    waitDone("fetch");

    // Fetch plus load: A before B, one joint resp
    applyStimulus(1'b1, 32'h60, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    rd_q.push_back(32'h0000_AAAA);
    rd_q.push_back(32'h0000_5555);
    pushAcc(1'b0, 32'h60, 32'h0, 4'hF, base + 1);
    pushAcc(1'b0, 32'h100, 32'h0, 4'hF, base + 2);
    model_a = 32'h0000_AAAA;
    model_b = 32'h0000_5555;
    pushCpl(base + 3);
    releaseInputs();
    waitDone("fetch_load");

    // Store with three wait cycles; rdata_b keeps the earlier load value
    mem_wait = 3;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
    pushAcc(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, base + 4);
    pushCpl(base + 5);
    releaseInputs();
    waitDone("store");

    // Simultaneous read_b and write_b: the write wins
    mem_wait = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'b1100);
    pushAcc(1'b1, 32'h40, 32'h1234_5678, 4'b1100, base + 1);
    pushCpl(base + 2);
    releaseInputs();
    waitDone("rw_priority");

    // Fetch plus store, one wait cycle per access
    mem_wait = 1;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 4'b0101);
    rd_q.push_back(32'h0000_1234);
    pushAcc(1'b0, 32'h80, 32'h0, 4'hF, base + 2);
    pushAcc(1'b1, 32'h300, 32'hCAFE_F00D, 4'b0101, base + 4);
    model_a = 32'h0000_1234;
    pushCpl(base + 5);
    releaseInputs();
    waitDone("fetch_store");

    // Request held through DONE: served again only from the following IDLE
    mem_wait = 0;
    applyStimulus(1'b1, 32'h70, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rd_q.push_back(32'h0000_0011);
    rd_q.push_back(32'h0000_0022);
    pushAcc(1'b0, 32'h70, 32'h0, 4'hF, base + 1);
    pushAcc(1'b0, 32'h70, 32'h0, 4'hF, base + 4);
    model_a = 32'h0000_0011;
    pushCpl(base + 2);
    model_a = 32'h0000_0022;
    pushCpl(base + 5);
    while (edge_count < base + 4) @(negedge clk);
    read_a = 1'b0;
    waitDone("held");

    // Reset while MEM_B waits: no resp, strobes low, read latches cleared
    mem_wait = 2;
    applyStimulus(1'b1, 32'h90, 1'b1, 1'b0, 32'h110, 32'h0, 4'h0);
    rd_q.push_back(32'h0000_3333);
    pushAcc(1'b0, 32'h90, 32'h0, 4'hF, base + 3);
    releaseInputs();
    while (edge_count < base + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_q.delete();
    #2;
    checkOutput("abort_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("abort_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("abort_rdata_a", rdata_a, 32'd0);
    checkOutput("abort_rdata_b", rdata_b, 32'd0);
    checkOutput("abort_resp_ab", {30'd0, resp_a, resp_b}, 32'd3);
    model_a = 32'd0;
    model_b = 32'd0;
    waitDone("abort");

    // Load only after the abort
    mem_wait = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    rd_q.push_back(32'h0000_0077);
    pushAcc(1'b0, 32'h104, 32'h0, 4'hF, base + 1);
    model_b = 32'h0000_0077;
    pushCpl(base + 2);
    releaseInputs();
    waitDone("load");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
